// File: rtl/vm_coin_feeder.sv
// vm_coin_feeder: synchronises and debounces two coin-slot sensors, queues
// accepted coins in a small FIFO and issues them as single-cycle 2-bit codes
// with an enforced idle gap between codes. Drops on a full FIFO pulse reject.
module vm_coin_feeder #(
  parameter int DEBOUNCE   = 3,
  parameter int GAP_CYCLES = 2,
  parameter int DEPTH      = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   coin5_raw,
  input  logic                   coin10_raw,
  input  logic                   hold,
  output logic [1:0]             coin_code,
  output logic                   reject,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic [7:0]             coins_issued
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int FW = CW + 1;
  localparam logic [3:0]    DB_LAST  = 4'(DEBOUNCE - 1);
  localparam logic [3:0]    GAP_LOAD = 4'(GAP_CYCLES);
  localparam logic [FW-1:0] DEPTH_F  = FW'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  logic [1:0]    r_sync5;
  logic [1:0]    r_sync10;
  logic [3:0]    r_db_cnt [2];
  logic [1:0]    r_armed;
  logic [1:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_reject;
  state_t        r_state;
  logic [3:0]    r_gap;
  logic [1:0]    r_code;
  logic [7:0]    r_issued;

  logic [1:0]    w_sync;
  logic [1:0]    w_acc;
  logic          w_pop;
  logic          w_push5;
  logic          w_push10;
  logic          w_drop;
  logic [FW-1:0] w_free;

  // Bit 0 is the 5-unit channel, bit 1 the 10-unit channel throughout.
  assign w_sync = {r_sync10[1], r_sync5[1]};

  // Two-flop synchronisers for the asynchronous slot sensors.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync5  <= 2'b00;
      r_sync10 <= 2'b00;
    end else begin
      r_sync5  <= {r_sync5[0], coin5_raw};
      r_sync10 <= {r_sync10[0], coin10_raw};
    end
  end

  // Accept event: armed channel whose high-sample run reaches DEBOUNCE on this edge.
  always_comb begin
    w_acc = 2'b00;
    for (int ch = 0; ch < 2; ch++) begin
      if (r_armed[ch] && w_sync[ch] && (r_db_cnt[ch] == DB_LAST)) begin
        w_acc[ch] = 1'b1;
      end else begin
        w_acc[ch] = 1'b0;
      end
    end
  end

  // Debounce: armed channels count highs to accept; disarmed channels count lows to re-arm.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_db_cnt[0] <= 4'd0;
      r_db_cnt[1] <= 4'd0;
      r_armed     <= 2'b11;
    end else begin
      for (int ch = 0; ch < 2; ch++) begin
        if (r_armed[ch]) begin
          if (!w_sync[ch]) begin
            r_db_cnt[ch] <= 4'd0;
          end else if (r_db_cnt[ch] == DB_LAST) begin
            r_db_cnt[ch] <= 4'd0;
            r_armed[ch]  <= 1'b0;
          end else begin
            r_db_cnt[ch] <= r_db_cnt[ch] + 4'd1;
          end
        end else begin
          if (w_sync[ch]) begin
            r_db_cnt[ch] <= 4'd0;
          end else if (r_db_cnt[ch] == DB_LAST) begin
            r_db_cnt[ch] <= 4'd0;
            r_armed[ch]  <= 1'b1;
          end else begin
            r_db_cnt[ch] <= r_db_cnt[ch] + 4'd1;
          end
        end
      end
    end
  end

  // Admission: a same-edge pop frees its slot first; the 5 entry has priority over the 10.
  always_comb begin
    w_pop    = (r_state == S_IDLE) && (r_count != '0) && !hold;
    w_free   = DEPTH_F - {1'b0, r_count} + FW'(w_pop);
    w_push5  = w_acc[0] && (w_free != '0);
    w_push10 = w_acc[1] && (w_free > FW'(w_push5));
    w_drop   = (w_acc[0] && !w_push5) || (w_acc[1] && !w_push10);
  end

  // Circular FIFO storage, pointers, occupancy and the registered reject pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= 2'd0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_reject <= 1'b0;
    end else begin
      if (w_push5) begin
        r_mem[r_wr_ptr] <= 2'd1;
      end
      if (w_push10) begin
        r_mem[w_push5 ? (r_wr_ptr + PTR_ONE) : r_wr_ptr] <= 2'd2;
      end
      r_wr_ptr <= r_wr_ptr + AW'(w_push5) + AW'(w_push10);
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end else begin
        r_rd_ptr <= r_rd_ptr;
      end
      r_count  <= r_count + CW'(w_push5) + CW'(w_push10) - CW'(w_pop);
      r_reject <= w_drop;
    end
  end

  // Issue FSM: pop in IDLE, drive the code for one ISSUE cycle, then hold zero for the gap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_gap    <= 4'd0;
      r_code   <= 2'd0;
      r_issued <= 8'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_code   <= r_mem[r_rd_ptr];
            r_issued <= r_issued + 8'd1;
            r_state  <= S_ISSUE;
          end else begin
            r_code   <= 2'd0;
          end
        end
        S_ISSUE: begin
          r_code <= 2'd0;
          if (GAP_LOAD != 4'd0) begin
            r_gap   <= GAP_LOAD;
            r_state <= S_GAP;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_GAP: begin
          r_code <= 2'd0;
          if (r_gap <= 4'd1) begin
            r_gap   <= 4'd0;
            r_state <= S_IDLE;
          end else begin
            r_gap <= r_gap - 4'd1;
          end
        end
        default: begin
          r_code  <= 2'd0;
          r_gap   <= 4'd0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign coin_code    = r_code;
  assign reject       = r_reject;
  assign fifo_count   = r_count;
  assign coins_issued = r_issued;

endmodule

// File: tb/tb_vm_coin_feeder.sv
// Self-checking bench for vm_coin_feeder: directed scenarios plus randomized
// sensor traffic, compared every cycle against a queue-based reference model.
module tb_vm_coin_feeder;

  localparam int D = 3;
  localparam int G = 2;
  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       c5 = 1'b0;
  logic       c10 = 1'b0;
  logic       hold = 1'b0;
  logic [1:0] coin_code;
  logic       reject;
  logic [2:0] fifo_count;
  logic [7:0] coins_issued;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [1:0] m_p5, m_p10;
  int         m_hi [2];
  int         m_lo [2];
  logic [1:0] m_armed;
  int         m_q [$];
  int         m_edge = 0;
  int         m_next_ok;
  logic [1:0] m_code;
  logic       m_rej;
  logic [2:0] m_cnt;
  logic [7:0] m_issued;

  vm_coin_feeder #(.DEBOUNCE(D), .GAP_CYCLES(G), .DEPTH(N)) dut (
    .clk(clk), .rst(rst), .coin5_raw(c5), .coin10_raw(c10), .hold(hold),
    .coin_code(coin_code), .reject(reject), .fifo_count(fifo_count),
    .coins_issued(coins_issued)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_p5 = 2'b00; m_p10 = 2'b00;
    m_hi[0] = 0; m_hi[1] = 0; m_lo[0] = 0; m_lo[1] = 0;
    m_armed = 2'b11;
    m_q.delete();
    m_next_ok = 0;
    m_code = 2'd0; m_rej = 1'b0; m_cnt = 3'd0; m_issued = 8'd0;
  endtask

  // One rising edge of the reference: raw seen two edges late, run-length debounce,
  // issue slots spaced 2+G edges apart, pop before pushes, 5 before 10.
  task automatic model_edge(input logic r5, input logic r10, input logic h);
    logic [1:0] s;
    logic [1:0] acc;
    s = {m_p10[1], m_p5[1]};
    m_p5 = {m_p5[0], r5};
    m_p10 = {m_p10[0], r10};
    acc = 2'b00;
    for (int ch = 0; ch < 2; ch++) begin
      if (m_armed[ch]) begin
        m_hi[ch] = s[ch] ? m_hi[ch] + 1 : 0;
        if (m_hi[ch] == D) begin acc[ch] = 1'b1; m_armed[ch] = 1'b0; m_lo[ch] = 0; end
      end else begin
        m_lo[ch] = s[ch] ? 0 : m_lo[ch] + 1;
        if (m_lo[ch] == D) begin m_armed[ch] = 1'b1; m_hi[ch] = 0; end
      end
    end
    if (m_q.size() > 0 && m_edge >= m_next_ok && !h) begin
      m_code = 2'(m_q.pop_front());
      m_issued = m_issued + 8'd1;
      m_next_ok = m_edge + G + 2;
    end else begin
      m_code = 2'd0;
    end
    m_rej = 1'b0;
    if (acc[0]) begin
      if (m_q.size() < N) m_q.push_back(1); else m_rej = 1'b1;
    end
    if (acc[1]) begin
      if (m_q.size() < N) m_q.push_back(2); else m_rej = 1'b1;
    end
    m_cnt = 3'(m_q.size());
    m_edge++;
  endtask

  // Drive inputs, take one rising edge, advance the model, settle 1 time unit.
  task automatic tick(input logic r5, input logic r10, input logic h);
    c5 = r5; c10 = r10; hold = h;
    @(posedge clk);
    if (!rst) model_reset(); else model_edge(r5, r10, h);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 2; i++) begin
      tick(1'b0, 1'b0, 1'b0);
      checks++;
      if ({coin_code, reject, fifo_count, coins_issued} !== 14'd0) begin
        errors++;
        $display("FAIL reset got code=%0d rej=%0d cnt=%0d iss=%0d expected all 0",
                 coin_code, reject, fifo_count, coins_issued);
      end
    end
    rst = 1'b1;
  endtask

  task automatic test_clean();
    int first_at = -1;
    int nz = 0;
    for (int i = 0; i < 20; i++) begin
      tick(i < 10, 1'b0, 1'b0);
      checks++;
      if ({coin_code, reject, fifo_count, coins_issued} !== {m_code, m_rej, m_cnt, m_issued}) begin
        errors++;
        $display("FAIL clean i=%0d got code=%0d rej=%0d cnt=%0d iss=%0d expected %0d %0d %0d %0d",
                 i, coin_code, reject, fifo_count, coins_issued, m_code, m_rej, m_cnt, m_issued);
      end
      if (coin_code != 2'd0) begin nz++; if (first_at < 0) first_at = i; end
    end
    checks++;
    if (nz != 1 || first_at != 5 || coins_issued !== 8'd1 || fifo_count !== 3'd0) begin
      errors++;
      $display("FAIL clean_latency got codes=%0d first_edge=%0d iss=%0d cnt=%0d expected 1 5 1 0",
               nz, first_at, coins_issued, fifo_count);
    end
  endtask

  task automatic test_bounce();
    int nz_bounce = 0;
    int nz = 0;
    logic [7:0] start_iss;
    logic r;
    start_iss = coins_issued;
    for (int i = 0; i < 26; i++) begin
      r = (i < 8) ? ((i % 2) == 0) : (i < 14);
      tick(1'b0, r, 1'b0);
      checks++;
      if ({coin_code, reject, fifo_count, coins_issued} !== {m_code, m_rej, m_cnt, m_issued}) begin
        errors++;
        $display("FAIL bounce i=%0d got code=%0d rej=%0d cnt=%0d iss=%0d expected %0d %0d %0d %0d",
                 i, coin_code, reject, fifo_count, coins_issued, m_code, m_rej, m_cnt, m_issued);
      end
      if (coin_code != 2'd0) begin
        if (i < 10) nz_bounce++;
        if (coin_code == 2'd2) nz++;
      end
    end
    checks++;
    if (nz != 1 || nz_bounce != 0 || coins_issued !== start_iss + 8'd1) begin
      errors++;
      $display("FAIL bounce_single got codes2=%0d early=%0d iss=%0d expected 1 0 %0d",
               nz, nz_bounce, coins_issued, start_iss + 8'd1);
    end
  endtask

  task automatic test_overflow();
    int rejects = 0;
    int got [$];
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < 12; i++) begin
        tick((k % 2 == 0) && i < 6, (k % 2 == 1) && i < 6, 1'b1);
        checks++;
        if ({coin_code, reject, fifo_count, coins_issued} !== {m_code, m_rej, m_cnt, m_issued}) begin
          errors++;
          $display("FAIL overflow_fill got code=%0d rej=%0d cnt=%0d iss=%0d expected %0d %0d %0d %0d",
                   coin_code, reject, fifo_count, coins_issued, m_code, m_rej, m_cnt, m_issued);
        end
        if (reject) rejects++;
      end
    end
    checks++;
    if (fifo_count !== 3'd4 || rejects != 1) begin
      errors++;
      $display("FAIL overflow_full got cnt=%0d rejects=%0d expected 4 1", fifo_count, rejects);
    end
    for (int i = 0; i < 24; i++) begin
      tick(1'b0, 1'b0, 1'b0);
      checks++;
      if ({coin_code, reject, fifo_count, coins_issued} !== {m_code, m_rej, m_cnt, m_issued}) begin
        errors++;
        $display("FAIL overflow_drain got code=%0d rej=%0d cnt=%0d iss=%0d expected %0d %0d %0d %0d",
                 coin_code, reject, fifo_count, coins_issued, m_code, m_rej, m_cnt, m_issued);
      end
      if (coin_code != 2'd0) got.push_back(int'(coin_code));
    end
    checks++;
    if (got.size() != 4 || got[0] != 1 || got[1] != 2 || got[2] != 1 || got[3] != 2) begin
      errors++;
      $display("FAIL overflow_order got %0d codes %p expected 1 2 1 2", got.size(), got);
    end
  endtask

  task automatic test_simul();
    int maxcnt = 0;
    int got [$];
    int at [$];
    for (int i = 0; i < 22; i++) begin
      tick(i < 6, i < 6, 1'b0);
      checks++;
      if ({coin_code, reject, fifo_count, coins_issued} !== {m_code, m_rej, m_cnt, m_issued}) begin
        errors++;
        $display("FAIL simul got code=%0d rej=%0d cnt=%0d iss=%0d expected %0d %0d %0d %0d",
                 coin_code, reject, fifo_count, coins_issued, m_code, m_rej, m_cnt, m_issued);
      end
      if (int'(fifo_count) > maxcnt) maxcnt = int'(fifo_count);
      if (coin_code != 2'd0) begin got.push_back(int'(coin_code)); at.push_back(i); end
    end
    checks++;
    if (maxcnt != 2 || got.size() != 2 || got[0] != 1 || got[1] != 2 || (at[1] - at[0]) < G + 1) begin
      errors++;
      $display("FAIL simul_order got maxcnt=%0d codes=%p expected 2 codes 1 then 2 spaced > %0d",
               maxcnt, got, G);
    end
  endtask

  task automatic test_async_reset();
    bit seen = 0;
    int nz = 0;
    for (int i = 0; i < 24; i++) tick(i < 6, i >= 12 && i < 18, 1'b1);
    for (int i = 0; i < 10 && !seen; i++) begin
      tick(1'b0, 1'b0, 1'b0);
      if (coin_code == 2'd2) seen = 1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL async_wait got no code 2 within 10 cycles expected code 2");
    end
    #2 rst = 1'b0;
    #1;
    model_reset();
    checks++;
    if ({coin_code, reject, fifo_count, coins_issued} !== 14'd0) begin
      errors++;
      $display("FAIL async_reset got code=%0d rej=%0d cnt=%0d iss=%0d expected all 0",
               coin_code, reject, fifo_count, coins_issued);
    end
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick(1'b0, 1'b0, 1'b0);
      checks++;
      if ({coin_code, reject, fifo_count, coins_issued} !== {m_code, m_rej, m_cnt, m_issued}) begin
        errors++;
        $display("FAIL async_after got code=%0d rej=%0d cnt=%0d iss=%0d expected %0d %0d %0d %0d",
                 coin_code, reject, fifo_count, coins_issued, m_code, m_rej, m_cnt, m_issued);
      end
      if (coin_code != 2'd0) nz++;
    end
    checks++;
    if (nz != 0) begin
      errors++;
      $display("FAIL async_quiet got %0d codes after reset expected 0", nz);
    end
  endtask

  task automatic test_wrap();
    int exp_q [$];
    int issued = 0;
    int kind;
    int e;
    for (int k = 0; k < 256 + 2; k++) begin
      kind = (k < 256) ? int'($urandom_range(1, 2)) : 0;
      if (kind != 0) exp_q.push_back(kind);
      for (int i = 0; i < 12; i++) begin
        tick(kind == 1 && i < 6, kind == 2 && i < 6, 1'b0);
        checks++;
        if ({coin_code, reject, fifo_count, coins_issued} !== {m_code, m_rej, m_cnt, m_issued}) begin
          errors++;
          $display("FAIL wrap_cycle got code=%0d rej=%0d cnt=%0d iss=%0d expected %0d %0d %0d %0d",
                   coin_code, reject, fifo_count, coins_issued, m_code, m_rej, m_cnt, m_issued);
        end
        if (coin_code != 2'd0) begin
          issued++;
          e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
          checks++;
          if (int'(coin_code) != e) begin
            errors++;
            $display("FAIL wrap_order n=%0d got code=%0d expected %0d", issued, coin_code, e);
          end
        end
      end
    end
    checks++;
    if (issued != 256 || coins_issued !== 8'd0 || exp_q.size() != 0 || fifo_count !== 3'd0) begin
      errors++;
      $display("FAIL wrap_total got issued=%0d iss=%0d left=%0d cnt=%0d expected 256 0 0 0",
               issued, coins_issued, exp_q.size(), fifo_count);
    end
  endtask

  task automatic test_random();
    logic l5 = 1'b0, l10 = 1'b0, lh = 1'b0;
    int n5 = 0, n10 = 0, nh = 0;
    for (int i = 0; i < 1500; i++) begin
      if (n5 == 0) begin l5 = ~l5; n5 = int'($urandom_range(1, 8)); end
      if (n10 == 0) begin l10 = ~l10; n10 = int'($urandom_range(1, 8)); end
      if (nh == 0) begin lh = ($urandom_range(0, 3) == 0); nh = int'($urandom_range(1, 20)); end
      tick(l5, l10, lh);
      n5--; n10--; nh--;
      checks++;
      if ({coin_code, reject, fifo_count, coins_issued} !== {m_code, m_rej, m_cnt, m_issued}) begin
        errors++;
        $display("FAIL random i=%0d got code=%0d rej=%0d cnt=%0d iss=%0d expected %0d %0d %0d %0d",
                 i, coin_code, reject, fifo_count, coins_issued, m_code, m_rej, m_cnt, m_issued);
      end
    end
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    test_reset();
    test_clean();
    test_bounce();
    test_overflow();
    test_simul();
    test_async_reset();
    test_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
